fetch_unit: RTL and testbench

//   Program-counter / fetch stage directly upstream of instruction_memory.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_if : signal bundle between the fetch stage, instruction memory and
//            decode.
//   master modport (fetch_unit):
//     in  stall, branch, branch_target, imem_data
//     out imem_addr, instr, instr_pc, instr_valid
//   slave modport (environment: memory + decode):
//     the same signals with the directions reversed
// ---------------------------------------------------------------------------
interface fetch_if #(
  parameter int DATA_W = 16
);
  logic              stall;          // decode cannot accept this cycle
  logic              branch;         // redirect fetch to branch_target
  logic [DATA_W-1:0] branch_target;  // redirect address
  logic [DATA_W-1:0] imem_addr;      // to instruction memory address port
  logic [DATA_W-1:0] imem_data;      // from instruction memory data port
  logic [DATA_W-1:0] instr;          // instruction to decode
  logic [DATA_W-1:0] instr_pc;       // address instr was fetched from
  logic              instr_valid;    // instr / instr_pc meaningful

  modport master (
    input  stall, branch, branch_target, imem_data,
    output imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output stall, branch, branch_target, imem_data,
    input  imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : program-counter / fetch stage in front of a synchronous
//              (registered-address) instruction memory.
//   clk  in  rising-edge clock, shared with the instruction memory
//   rst  in  asynchronous, active-high reset
//   bus  fetch_if.master
//     stall / branch / branch_target : control from decode / execute
//     imem_addr -> memory, imem_data <- memory
//     instr / instr_pc / instr_valid : tagged instruction stream to decode
//
// The memory registers the address on every edge, so whatever is on
// imem_addr at edge N is the instruction visible in cycle N+1. iss_pc_q
// remembers that address so the returned data can be tagged with its PC.
// All addresses are kept at log2(MEM_WORD) bits, so wrap-around and
// truncation of branch targets fall out of the arithmetic; upper output
// bits are driven to zero.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int MEM_WORD = 256,  // power of two, at least 2
  parameter int RESET_PC = 0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int AW = $clog2(MEM_WORD);

  typedef logic [AW-1:0] addr_t;

  localparam addr_t RESET_A = addr_t'(RESET_PC);

  addr_t pc_q, pc_d;          // next sequential address to issue
  addr_t iss_pc_q, iss_pc_d;  // address the memory latched on the last edge
  logic  iss_vld_q, iss_vld_d;
  addr_t tgt;
  addr_t issue_addr;
  logic  stl;

  // Next-state and address mux. Priority: branch, effective stall, sequential.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_d       = pc_q;
    iss_pc_d   = iss_pc_q;
    iss_vld_d  = iss_vld_q;
    tgt        = bus.branch_target[AW-1:0];
    // A stall only matters when there is a real instruction to hold;
    // a branch in the same cycle consumes that instruction instead.
    stl        = bus.stall & iss_vld_q & ~bus.branch;

    if (bus.branch) begin
      iss_pc_d  = tgt;
      iss_vld_d = 1'b1;
      pc_d      = tgt + addr_t'(1);
    end else if (!stl) begin
      iss_pc_d  = pc_q;
      iss_vld_d = 1'b1;
      pc_d      = pc_q + addr_t'(1);
    end

    // While stalled the memory re-latches the held address, so its output
    // (and therefore instr) stays put without any data register here.
    if (rst)             issue_addr = RESET_A;
    else if (bus.branch) issue_addr = tgt;
    else if (stl)        issue_addr = iss_pc_q;
    else                 issue_addr = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all flop updates so every register samples pre-edge values.
      pc_q      <= RESET_A;
      iss_pc_q  <= RESET_A;
      iss_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      iss_pc_q  <= iss_pc_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  // Outputs: zero-extend the AW-bit addresses to the bus width.
  always_comb begin
    bus.imem_addr         = '0;
    bus.imem_addr[AW-1:0] = issue_addr;
    bus.instr_pc          = '0;
    bus.instr_pc[AW-1:0]  = iss_pc_q;
  end

  // Data passes straight through; it never feeds any control decision.
  assign bus.instr       = bus.imem_data;
  assign bus.instr_valid = iss_vld_q;

  // Target bits above the memory size are deliberately ignored.
  if (AW < DATA_W) begin : g_tgt_hi
    logic unused_tgt_hi;
    assign unused_tgt_hi = ^bus.branch_target[DATA_W-1:AW];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed, table-driven bench for fetch_unit with a
// behavioural registered-address instruction memory holding
// mem[i] = 16'hA000 + i. Each table row is one clock cycle: drive inputs,
// compare outputs on the falling edge, then advance one rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int DATA_W   = 16;
  localparam int MEM_WORD = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fetch_if #(.DATA_W(DATA_W)) bus ();

  fetch_unit #(
    .DATA_W  (DATA_W),
    .MEM_WORD(MEM_WORD),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory model: address registered on every rising edge.
  logic [DATA_W-1:0] mem [MEM_WORD];
  logic [DATA_W-1:0] mem_addr_q;

  initial for (int i = 0; i < MEM_WORD; i++) mem[i] = 16'hA000 + 16'(i);

  always @(posedge clk) mem_addr_q <= bus.imem_addr;
  assign bus.imem_data = mem[mem_addr_q[7:0]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        branch;
    logic [15:0] target;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [21];

  task automatic drive(input logic s, input logic b, input logic [15:0] t);
    bus.stall         = s;
    bus.branch        = b;
    bus.branch_target = t;
  endtask

  // Compare all outputs against a hand-computed expectation at the falling edge.
  task automatic check_outputs(input string tag, input logic v, input logic [15:0] pc,
                               input logic [15:0] addr);
    check({tag, ".valid"}, 32'(bus.instr_valid), 32'(v));
    check({tag, ".pc"},    32'(bus.instr_pc),    32'(pc));
    check({tag, ".addr"},  32'(bus.imem_addr),   32'(addr));
    if (v) check({tag, ".instr"}, 32'(bus.instr), 32'(16'hA000 + pc));
  endtask

  task automatic cycle(input string tag, input logic s, input logic b, input logic [15:0] t,
                       input logic v, input logic [15:0] pc, input logic [15:0] addr);
    drive(s, b, t);
    @(negedge clk);
    check_outputs(tag, v, pc, addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rows: stall, branch, target, exp_valid, exp_pc, exp_addr
    // Start-up and sequential fetch
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002};
    // Three-cycle stall holding PC 2
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0002};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0002};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0002};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0004};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0005};
    // Branch to 0x40 while PC 5 is shown
    vecs[9]  = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0005, 16'h0040};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0041};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'h0042};
    // Branch and stall together: branch wins, then the stall holds 0x10
    vecs[12] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0042, 16'h0010};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0010};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0010};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0011};
    // Wrap at the top of memory, then a truncated target
    vecs[16] = '{1'b0, 1'b1, 16'h00FF, 1'b1, 16'h0011, 16'h00FF};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h00FF, 16'h0000};
    vecs[18] = '{1'b0, 1'b1, 16'h01FF, 1'b1, 16'h0000, 16'h00FF};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h00FF, 16'h0000};
    vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001};

    // Reset, with a branch request present to show reset owns the address mux.
    drive(1'b0, 1'b1, 16'h0033);
    #2 rst = 1'b1;
    @(negedge clk);
    check("reset.valid", 32'(bus.instr_valid), 32'd0);
    check("reset.pc",    32'(bus.instr_pc),    32'h0);
    check("reset.addr",  32'(bus.imem_addr),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].stall, vecs[i].branch, vecs[i].target,
            vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_addr);
    end

    // Run sequentially until PC 7 is on the output, within a cycle budget.
    begin
      bit found = 1'b0;
      drive(1'b0, 1'b0, 16'h0000);
      for (int n = 0; n < 20 && !found; n++) begin
        @(negedge clk);
        if (bus.instr_valid && bus.instr_pc == 16'h0007) found = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      check("reach_pc7", 32'(found), 32'd1);
    end

    // Asynchronous reset mid-stream: takes effect before the next edge.
    #1 rst = 1'b1;
    #1;
    check("async_rst.valid", 32'(bus.instr_valid), 32'd0);
    check("async_rst.addr",  32'(bus.imem_addr),   32'h0);
    check("async_rst.pc",    32'(bus.instr_pc),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Restart from address 0; a stall with nothing valid is ignored.
    cycle("restart0", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    cycle("restart1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000);
    cycle("restart2", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001);
    cycle("restart3", 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
